// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one i2c_master between N_REQ requesters.
// It grants one request, latches its command, issues a single start, and returns done/err/rdata.
module i2c_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         rdata,
  output logic               m_start,
  output logic [6:0]         m_addr,
  output logic               m_rw,
  output logic [7:0]         m_wdata,
  input  logic               m_busy,
  input  logic [7:0]         m_rdata,
  input  logic               m_nack,
  output logic [2:0]         dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    COMPLETE  = 3'd4
  } state_t;

  // Handshake: req[i] is a level request held until done[i]/err[i]; the command
  // is captured in the grant cycle, so later changes on req/req_* are ignored.
  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic [6:0]       m_addr_q, m_addr_d;
  logic             m_rw_q, m_rw_d;
  logic [7:0]       m_wdata_q, m_wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_flag_q, err_flag_d;
  logic             busy_meta_q, busy_s_q;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] completion;
  logic             any_elig;
  logic [IW-1:0]    sel_idx;
  int               cand;
  logic [6:0]       sel_addr;
  logic             sel_rw;
  logic [7:0]       sel_wdata;
  logic [CW-1:0]    cnt_inc;
  logic             expire;

  assign eligible   = req & ~served_q;
  assign completion = (state_q == COMPLETE) ? grant_q : '0;

  // First eligible requester searching upward from ptr, wrapping at N_REQ.
  always_comb begin
    any_elig  = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any_elig && eligible[cand[IW-1:0]]) begin
        any_elig = 1'b1;
        sel_idx  = cand[IW-1:0];
      end
    end
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_addr  = req_addr[7*i +: 7];
        sel_rw    = req_rw[i];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      served_q    <= '0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_wdata_q   <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      err_flag_q  <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      served_q    <= served_d;
      m_addr_q    <= m_addr_d;
      m_rw_q      <= m_rw_d;
      m_wdata_q   <= m_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      err_flag_q  <= err_flag_d;
      busy_meta_q <= m_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    m_addr_d   = m_addr_q;
    m_rw_d     = m_rw_q;
    m_wdata_d  = m_wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    // Saturating count; a phase expires on the cycle the count would reach TIMEOUT-1.
    cnt_inc    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    expire     = (cnt_inc == CW'(TIMEOUT - 1));
    // A request dropped during its own completion is not held, so served stays clear.
    served_d   = (served_q | completion) & req;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          gidx_d           = sel_idx;
          m_addr_d         = sel_addr;
          m_rw_d           = sel_rw;
          m_wdata_d        = sel_wdata;
          err_flag_d       = 1'b0;
          state_d          = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy_s_q) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (expire) begin
          err_flag_d = 1'b1;
          state_d    = COMPLETE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!busy_s_q) begin
          err_flag_d = m_nack;
          if (m_rw_q && !m_nack) rdata_d = m_rdata;
          state_d = COMPLETE;
        end else if (expire) begin
          err_flag_d = 1'b1;
          state_d    = COMPLETE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      COMPLETE: begin
        grant_d = '0;
        ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_start   = (state_q == LAUNCH);
    done      = (state_q == COMPLETE && !err_flag_q) ? grant_q : '0;
    err       = (state_q == COMPLETE &&  err_flag_q) ? grant_q : '0;
    dbg_state = state_q;
  end

  assign grant   = grant_q;
  assign rdata   = rdata_q;
  assign m_addr  = m_addr_q;
  assign m_rw    = m_rw_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a table of single transactions followed by
// hand-written round-robin, held-request, pointer-after-timeout and reset sequences.
module tb_i2c_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 32;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   grant, done, err;
  logic [7:0]     rdata;
  logic           m_start;
  logic [6:0]     m_addr;
  logic           m_rw;
  logic [7:0]     m_wdata;
  logic           m_busy;
  logic [7:0]     m_rdata;
  logic           m_nack;
  logic [2:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic [6:0] addr_a [N];
  logic       rw_a   [N];
  logic [7:0] wd_a   [N];

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    int         busy_len;
    logic       nack;
    logic [7:0] mrd;
    int         mode;      // 0 normal, 1 master never busy, 2 master never finishes
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  i2c_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_rw      (m_rw),
    .m_wdata   (m_wdata),
    .m_busy    (m_busy),
    .m_rdata   (m_rdata),
    .m_nack    (m_nack),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic set_cfg(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    addr_a[i] = a;
    rw_a[i]   = rw;
    wd_a[i]   = wd;
    req_addr[7*i +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[8*i +: 8] = wd;
  endtask

  // Waits for the grant of requester idx, plays the master, checks the completion.
  task automatic serve(input int idx, input int busy_len, input logic nack, input logic [7:0] mrd,
                       input int mode, input logic exp_err, input logic [7:0] exp_rdata,
                       input logic drop_req, input string tag);
    logic         seen;
    int           n;
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = m_start;
    end
    check({tag, ".start_seen"}, int'(seen), 1);
    if (!seen) return;
    check({tag, ".grant"},   int'(grant),   int'(oh));
    check({tag, ".m_addr"},  int'(m_addr),  int'(addr_a[idx]));
    check({tag, ".m_rw"},    int'(m_rw),    int'(rw_a[idx]));
    check({tag, ".m_wdata"}, int'(m_wdata), int'(wd_a[idx]));
    n = 0;
    if (mode == 1) begin
      while (n < TO + 8 && done == '0 && err == '0) begin
        @(negedge clk);
        n++;
      end
      check({tag, ".timeout_latency"}, n, TO);
    end else begin
      @(negedge clk);
      check({tag, ".start_one_cycle"}, int'(m_start), 0);
      @(negedge clk);
      m_busy = 1'b1;
      if (mode == 2) begin
        while (n < TO + 12 && done == '0 && err == '0) begin
          @(negedge clk);
          n++;
        end
        check({tag, ".done_timeout_latency"}, n, TO + 2);
      end else begin
        repeat (busy_len) @(negedge clk);
        check({tag, ".m_addr_held"}, int'(m_addr), int'(addr_a[idx]));
        m_busy  = 1'b0;
        m_nack  = nack;
        m_rdata = mrd;
        while (n < 10 && done == '0 && err == '0) begin
          @(negedge clk);
          n++;
        end
        check({tag, ".completion_latency"}, n, 3);
      end
    end
    check({tag, ".done"},  int'(done),  exp_err ? 0 : int'(oh));
    check({tag, ".err"},   int'(err),   exp_err ? int'(oh) : 0);
    check({tag, ".grant_at_complete"}, int'(grant), int'(oh));
    check({tag, ".rdata"}, int'(rdata), int'(exp_rdata));
    m_busy = 1'b0;
    m_nack = 1'b0;
    if (drop_req) req[idx] = 1'b0;
    @(negedge clk);
    check({tag, ".pulse_end"},   int'(done | err), 0);
    check({tag, ".grant_clear"}, int'(grant),      0);
  endtask

  initial begin
    logic seen;
    logic [7:0] e;

    vecs[0] = '{1, 7'h50, 1'b0, 8'hA5, 20, 1'b0, 8'h77, 0, 1'b0, 8'h00};
    vecs[1] = '{2, 7'h2A, 1'b1, 8'h00,  5, 1'b1, 8'h3C, 0, 1'b1, 8'h00};
    vecs[2] = '{2, 7'h2A, 1'b1, 8'h00,  5, 1'b0, 8'h3C, 0, 1'b0, 8'h3C};
    vecs[3] = '{0, 7'h11, 1'b1, 8'h00,  3, 1'b0, 8'hE1, 0, 1'b0, 8'hE1};
    vecs[4] = '{3, 7'h7F, 1'b0, 8'hFF,  1, 1'b1, 8'h55, 0, 1'b1, 8'hE1};
    vecs[5] = '{1, 7'h05, 1'b1, 8'h00,  4, 1'b0, 8'h00, 1, 1'b1, 8'hE1};
    vecs[6] = '{0, 7'h22, 1'b1, 8'h00,  0, 1'b0, 8'h00, 2, 1'b1, 8'hE1};
    vecs[7] = '{3, 7'h60, 1'b0, 8'h3C,  2, 1'b0, 8'h99, 0, 1'b0, 8'hE1};

    reset     = 1'b1;
    req       = '0;
    req_addr  = '0;
    req_rw    = '0;
    req_wdata = '0;
    m_busy    = 1'b0;
    m_rdata   = '0;
    m_nack    = 1'b0;
    for (int i = 0; i < N; i++) set_cfg(i, 7'h00, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("reset.grant",   int'(grant),     0);
    check("reset.done",    int'(done),      0);
    check("reset.err",     int'(err),       0);
    check("reset.rdata",   int'(rdata),     0);
    check("reset.m_start", int'(m_start),   0);
    check("reset.m_addr",  int'(m_addr),    0);
    check("reset.m_wdata", int'(m_wdata),   0);
    check("reset.state",   int'(dbg_state), int'(S_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Table of isolated transactions
    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v].idx, vecs[v].addr, vecs[v].rw, vecs[v].wdata);
      req[vecs[v].idx] = 1'b1;
      serve(vecs[v].idx, vecs[v].busy_len, vecs[v].nack, vecs[v].mrd, vecs[v].mode,
            vecs[v].exp_err, vecs[v].exp_rdata, 1'b1, $sformatf("vec%0d", v));
    end

    // Round robin with all four held, each released after its completion
    for (int i = 0; i < N; i++) set_cfg(i, 7'(8'h10 + i), 1'b0, 8'(8'hC0 + i));
    req = 4'b1111;
    for (int i = 0; i < N; i++) exp_q.push_back(8'(i));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      serve(int'(e), 2, 1'b0, 8'h00, 0, 1'b0, 8'hE1, 1'b1, $sformatf("rr%0d", e));
    end
    req[0] = 1'b1;
    req[2] = 1'b1;
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      serve(int'(e), 2, 1'b0, 8'h00, 0, 1'b0, 8'hE1, 1'b1, $sformatf("rr2_%0d", e));
    end

    // Held request is not re-served until it drops and rises again
    req[3] = 1'b1;
    serve(3, 2, 1'b0, 8'h00, 0, 1'b0, 8'hE1, 1'b0, "held_first");
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_start) seen = 1'b1;
    end
    check("held.no_restart", int'(seen),      0);
    check("held.state_idle", int'(dbg_state), int'(S_IDLE));
    req[3] = 1'b0;
    @(negedge clk);
    req[3] = 1'b1;
    serve(3, 2, 1'b0, 8'h00, 0, 1'b0, 8'hE1, 1'b1, "held_again");

    // Pointer advances past a timed-out requester
    set_cfg(1, 7'h05, 1'b1, 8'h00);
    req[1] = 1'b1;
    serve(1, 0, 1'b0, 8'h00, 1, 1'b1, 8'hE1, 1'b1, "to_ptr");
    check("to_ptr.state_idle", int'(dbg_state), int'(S_IDLE));
    req[0] = 1'b1;
    req[3] = 1'b1;
    serve(3, 2, 1'b0, 8'h00, 0, 1'b0, 8'hE1, 1'b1, "after_to_3");
    serve(0, 2, 1'b0, 8'h00, 0, 1'b0, 8'hE1, 1'b1, "after_to_0");

    // Reset in WAIT_DONE, then the still-pending request is granted again
    set_cfg(2, 7'h33, 1'b1, 8'h00);
    req[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = m_start;
    end
    check("rst.start_seen", int'(seen), 1);
    repeat (2) @(negedge clk);
    m_busy = 1'b1;
    repeat (6) @(negedge clk);
    check("rst.in_wait_done", int'(dbg_state), int'(S_WAIT_DONE));
    reset = 1'b1;
    #1;
    check("rst.grant",   int'(grant),     0);
    check("rst.m_addr",  int'(m_addr),    0);
    check("rst.m_rw",    int'(m_rw),      0);
    check("rst.rdata",   int'(rdata),     0);
    check("rst.done_err", int'(done | err), 0);
    check("rst.m_start", int'(m_start),   0);
    check("rst.state",   int'(dbg_state), int'(S_IDLE));
    m_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    serve(2, 3, 1'b0, 8'h4D, 0, 1'b0, 8'h4D, 1'b1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Round-robin arbiter and transaction sequencer that shares one `i2c_master` between `N_REQ` independent requesters. It sits between on-chip clients and the `i2c_master` command interface. It grants one request at a time, latches that request's address, direction and write data, and issues a single start pulse. It then tracks the master's `busy` handshake and returns completion, read data and error status to the granted requester.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 1024, clk cycles allowed per wait phase before a transaction is aborted (≥4)
- `clk` in 1: system clock
- `reset` in 1: reset, asynchronous, active-high; clock clk
- `req` in N_REQ: level request per requester; held until its `done`/`err`
- `req_addr` in 7*N_REQ: packed slave addresses, requester i at [7i+6:7i]
- `req_rw` in N_REQ: 1 = read, 0 = write
- `req_wdata` in 8*N_REQ: packed write bytes, requester i at [8i+7:8i]
- `grant` out N_REQ: one-hot, high from grant through completion
- `done` out N_REQ: 1-cycle pulse, transaction finished with ACK
- `err` out N_REQ: 1-cycle pulse, NACK or timeout
- `rdata` out 8: read byte; valid in the `done` cycle and held until the next completion
- `m_start` out 1: 1-cycle start pulse to the master
- `m_addr` out 7, `m_rw` out 1, `m_wdata` out 8: latched command, stable from LAUNCH through COMPLETE
- `m_busy` in 1: master busy; may be slower-clock domain, double-flop synchronised internally
- `m_rdata` in 8, `m_nack` in 1: sampled in the cycle synchronised `m_busy` falls

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE.
- Eligible requester i: `req[i]=1` and `served[i]=0`.
- `served[i]` is set when requester i receives `done` or `err`. It clears in the first cycle `req[i]=0`. A held request is therefore never re-served.
- IDLE: if any requester is eligible, select the first eligible index searching upward from `ptr` (wrapping). Register `grant`, `m_addr`, `m_rw`, `m_wdata` from that index. Go to LAUNCH.
- LAUNCH: `m_start=1` for exactly one cycle. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY: if synced busy=1, go to WAIT_DONE and clear the counter. If counter reaches TIMEOUT-1, set `err_flag` and go to COMPLETE.
- WAIT_DONE: if synced busy=0, capture `m_rdata` and `m_nack` and go to COMPLETE. If the timeout expires, set `err_flag` and go to COMPLETE.
- COMPLETE:
  - pulse `done[g]` if there is no NACK and no timeout, otherwise pulse `err[g]`;
  - load `rdata` only on a read `done`;
  - clear `grant`;
  - `ptr <= (g+1) mod N_REQ`;
  - go to IDLE.
- Changes to `req`, `req_*` after grant are ignored; the command is latched. A requester dropping `req` mid-transaction does not abort it, and still receives its `done`/`err`.
- Timeout counter width is `$clog2(TIMEOUT)`; it saturates and does not wrap.

## Timing
- Reset values: `grant=0`, `done=0`, `err=0`, `rdata=0`, `m_start=0`, `m_addr=0`, `m_rw=0`, `m_wdata=0`, `ptr=0`, `served=0`, state IDLE.
- Reset mid-transaction returns to IDLE immediately. The master is not aborted by this block; it shares the same reset.
- Request is seen in IDLE at cycle T, `grant` is high at T+1 (LAUNCH), and `m_start` is high during T+1.
- Completion: `done`/`err` pulse 3 cycles after raw `m_busy` falls (2 sync stages plus COMPLETE).
- The earliest next grant is the cycle after COMPLETE. Minimum gap between `m_start` pulses is 4 cycles plus the busy period.
- `grant` and `done`/`err` for the same requester are never high for different indices at once; at most one bit is set.

## Test plan
- Single write: `req[1]=1`, addr 0x50, wdata 0xA5, model busy 20 cycles → `m_start` one pulse, `m_addr=0x50`, `m_wdata=0xA5`, `done[1]` pulse, no `err`.
- Round-robin: `req=4'b1111` held, each released after its `done` → grant order 0,1,2,3; then re-raise `req[0]` and `req[2]` → order 0,2.
- Held request not re-served: `req[3]` kept high after `done[3]` → no second `m_start` until `req[3]` drops and rises again.
- Read with NACK: `req_rw[2]=1`, model returns `m_nack=1`, `m_rdata=0x3C` → `err[2]` pulse, `rdata` unchanged; repeat with ACK → `done[2]`, `rdata=0x3C`.
- Timeout: model never raises `m_busy` with TIMEOUT=16 → `err` pulse 16 cycles after LAUNCH, state returns to IDLE, `ptr` advances.
- Reset mid-WAIT_DONE → all outputs at reset values next cycle; the pending request is re-granted after reset is released.
